// File: rtl/bpr_pkg.sv
// Shared definitions for the bad-pixel-replacer pipeline stages.
// Frame geometry defaults and the line-window controller state encoding.
package bpr_pkg;

   localparam int PIX_W   = 15;
   localparam int LINE_W  = 640;
   localparam int FRAME_H = 512;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

endpackage

// File: rtl/bpr_line_ram.sv
// Simple dual-port line RAM with a registered, read-before-write read port.
// A same-address write and read in one cycle returns the previous contents.
module bpr_line_ram #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 15,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/bpr_line_window.sv
// Raster stream to vertical 3-pixel windows (above, centre, below) with
// edge-row replication at the top and bottom of the frame.
module bpr_line_window #(
   parameter int PIX_W   = bpr_pkg::PIX_W,
   parameter int LINE_W  = bpr_pkg::LINE_W,
   parameter int FRAME_H = bpr_pkg::FRAME_H
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [PIX_W-1:0] s_pix,
   input  logic             s_valid,
   input  logic             s_sof,
   output logic             s_ready,
   output logic [PIX_W-1:0] win_pix_0,
   output logic [PIX_W-1:0] win_pix_1,
   output logic [PIX_W-1:0] win_pix_2,
   output logic             win_valid,
   output logic             win_sof,
   output logic             win_eol
);

   import bpr_pkg::*;

   localparam int CW = $clog2(LINE_W);
   localparam int RW = $clog2(FRAME_H);
   localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);

   state_t state_reg, state_next;
   logic [CW-1:0] col_reg, col_next;
   logic [RW-1:0] row_reg, row_next;

   logic             accept;
   logic             emit, emit_top_c, emit_flush, emit_sof, emit_eol;
   logic             c_we, rd_en;
   logic [CW-1:0]    c_waddr;
   logic [PIX_W-1:0] rd_c, rd_t;

   logic             p1_valid, p1_top_c, p1_flush, p1_sof, p1_eol;
   logic [CW-1:0]    p1_col;
   logic [PIX_W-1:0] p1_pix;

   assign s_ready = (state_reg != FLUSH);
   assign accept  = s_valid & s_ready;

   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      emit       = 1'b0;
      emit_top_c = 1'b0;
      emit_flush = 1'b0;
      c_we       = 1'b0;
      c_waddr    = col_reg;
      rd_en      = 1'b0;
      case (state_reg)
         FLUSH: begin
            emit       = 1'b1;
            emit_flush = 1'b1;
            rd_en      = 1'b1;
            if (col_reg == COL_LAST) begin
               col_next   = '0;
               state_next = IDLE;
            end else begin
               col_next = col_reg + 1'b1;
            end
         end
         default: begin
            if (accept) begin
               if (s_sof) begin
                  // The sof pixel itself is stored as (0,0); the next pixel is column 1.
                  c_we       = 1'b1;
                  c_waddr    = '0;
                  col_next   = CW'(1);
                  row_next   = '0;
                  state_next = FILL;
               end else if (state_reg == FILL) begin
                  c_we = 1'b1;
                  if (col_reg == COL_LAST) begin
                     col_next   = '0;
                     row_next   = RW'(1);
                     state_next = RUN;
                  end else begin
                     col_next = col_reg + 1'b1;
                  end
               end else if (state_reg == RUN) begin
                  c_we       = 1'b1;
                  emit       = 1'b1;
                  rd_en      = 1'b1;
                  emit_top_c = (row_reg == RW'(1));
                  if (col_reg == COL_LAST) begin
                     col_next = '0;
                     if (row_reg == ROW_LAST) begin
                        row_next   = '0;
                        state_next = FLUSH;
                     end else begin
                        row_next = row_reg + 1'b1;
                     end
                  end else begin
                     col_next = col_reg + 1'b1;
                  end
               end
            end
         end
      endcase
   end

   assign emit_sof = emit & ~emit_flush & (row_reg == RW'(1)) & (col_reg == '0);
   assign emit_eol = emit & (col_reg == COL_LAST);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_reg <= IDLE;
         col_reg   <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
      end
   end

   bpr_line_ram #(.DEPTH(LINE_W), .WIDTH(PIX_W)) u_lb_c (
      .clk   (clk),
      .we    (c_we),
      .waddr (c_waddr),
      .wdata (s_pix),
      .re    (rd_en),
      .raddr (col_reg),
      .rdata (rd_c)
   );

   // lb_t takes the old lb_c word one cycle after the read that fetched it.
   bpr_line_ram #(.DEPTH(LINE_W), .WIDTH(PIX_W)) u_lb_t (
      .clk   (clk),
      .we    (p1_valid & ~p1_flush),
      .waddr (p1_col),
      .wdata (rd_c),
      .re    (rd_en),
      .raddr (col_reg),
      .rdata (rd_t)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         p1_valid <= 1'b0;
         p1_top_c <= 1'b0;
         p1_flush <= 1'b0;
         p1_sof   <= 1'b0;
         p1_eol   <= 1'b0;
         p1_col   <= '0;
         p1_pix   <= '0;
      end else begin
         p1_valid <= emit;
         if (emit) begin
            p1_top_c <= emit_top_c;
            p1_flush <= emit_flush;
            p1_sof   <= emit_sof;
            p1_eol   <= emit_eol;
            p1_col   <= col_reg;
            p1_pix   <= s_pix;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         win_valid <= 1'b0;
         win_sof   <= 1'b0;
         win_eol   <= 1'b0;
         win_pix_0 <= '0;
         win_pix_1 <= '0;
         win_pix_2 <= '0;
      end else begin
         win_valid <= p1_valid;
         win_sof   <= p1_valid & p1_sof;
         win_eol   <= p1_valid & p1_eol;
         if (p1_valid) begin
            win_pix_0 <= p1_top_c ? rd_c : rd_t;
            win_pix_1 <= rd_c;
            win_pix_2 <= p1_flush ? rd_c : p1_pix;
         end
      end
   end

endmodule

// File: tb/tb_bpr_line_window.sv
// Randomised bench for bpr_line_window against a frame-image reference model.
module tb_bpr_line_window;

   localparam int PW = 15;
   localparam int LW = 4;
   localparam int FH = 3;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic [PW-1:0] s_pix = '0;
   logic          s_valid = 1'b0;
   logic          s_sof = 1'b0;
   logic          s_ready;
   logic [PW-1:0] win_pix_0, win_pix_1, win_pix_2;
   logic          win_valid, win_sof, win_eol;

   bpr_line_window #(.PIX_W(PW), .LINE_W(LW), .FRAME_H(FH)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .s_pix     (s_pix),
      .s_valid   (s_valid),
      .s_sof     (s_sof),
      .s_ready   (s_ready),
      .win_pix_0 (win_pix_0),
      .win_pix_1 (win_pix_1),
      .win_pix_2 (win_pix_2),
      .win_valid (win_valid),
      .win_sof   (win_sof),
      .win_eol   (win_eol)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int p0, p1, p2;
      bit sof, eol;
   } win_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   not_ready_cnt = 0;
   win_t exp_q[$];
   win_t got[$];
   int   img [FH][LW];
   bit   in_frame = 0;
   int   mr = 0, mc = 0, flush_left = 0;

   task automatic push_win(input int due, input int y, input int x, input bit flush, input int bottom);
      win_t w;
      w.due = due;
      w.p0  = (y == 0) ? img[0][x] : img[y-1][x];
      w.p1  = img[y][x];
      w.p2  = flush ? img[y][x] : bottom;
      w.sof = (y == 0) && (x == 0);
      w.eol = (x == LW - 1);
      exp_q.push_back(w);
   endtask

   // Reference: every output cycle is checked against the queue of predicted windows.
   always @(negedge clk) begin
      if (!arst_n) begin
         exp_q.delete();
         in_frame   = 0;
         flush_left = 0;
      end else begin
         bit   exp_now;
         bit   ready_exp;
         win_t e, g;
         cyc++;
         exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         checks++;
         if (win_valid !== exp_now) begin
            errors++;
            $display("FAIL win_valid cyc %0d got %0b exp %0b", cyc, win_valid, exp_now);
         end
         if (exp_now) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(win_pix_0) != e.p0 || int'(win_pix_1) != e.p1 || int'(win_pix_2) != e.p2 ||
                win_sof !== e.sof || win_eol !== e.eol) begin
               errors++;
               $display("FAIL window cyc %0d got {%0d,%0d,%0d} sof %0b eol %0b exp {%0d,%0d,%0d} sof %0b eol %0b",
                        cyc, win_pix_0, win_pix_1, win_pix_2, win_sof, win_eol,
                        e.p0, e.p1, e.p2, e.sof, e.eol);
            end
         end else begin
            checks++;
            if (win_sof !== 1'b0 || win_eol !== 1'b0) begin
               errors++;
               $display("FAIL idle_flags cyc %0d got sof %0b eol %0b exp 0 0", cyc, win_sof, win_eol);
            end
         end
         if (win_valid === 1'b1) begin
            g.due = cyc; g.p0 = int'(win_pix_0); g.p1 = int'(win_pix_1); g.p2 = int'(win_pix_2);
            g.sof = win_sof; g.eol = win_eol;
            got.push_back(g);
         end

         ready_exp = (flush_left == 0);
         checks++;
         if (s_ready !== ready_exp) begin
            errors++;
            $display("FAIL s_ready cyc %0d got %0b exp %0b", cyc, s_ready, ready_exp);
         end
         if (s_ready === 1'b0)
            not_ready_cnt++;

         if (flush_left > 0) begin
            push_win(cyc + 2, FH - 1, LW - flush_left, 1'b1, 0);
            flush_left--;
         end else if (s_valid) begin
            if (s_sof) begin
               img[0][0] = int'(s_pix);
               mr = 0; mc = 1; in_frame = 1;
            end else if (in_frame) begin
               img[mr][mc] = int'(s_pix);
               if (mr >= 1)
                  push_win(cyc + 2, mr - 1, mc, 1'b0, int'(s_pix));
               mc++;
               if (mc == LW) begin
                  mc = 0;
                  mr++;
                  if (mr == FH) begin
                     in_frame   = 0;
                     flush_left = LW;
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [PW-1:0] pix, input logic sof, input int bub);
      int guard;
      while (bub > 0 && $urandom_range(0, 99) < bub) begin
         s_valid = 1'b0; s_sof = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b1; s_pix = pix; s_sof = sof;
      guard = 0;
      @(negedge clk);
      while (s_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         checks++; errors++;
         $display("FAIL ready_timeout got s_ready %0b exp 1", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_sof = 1'b0;
   endtask

   task automatic send_frame(input int bub, input bit rnd);
      for (int r = 0; r < FH; r++)
         for (int c = 0; c < LW; c++)
            send(rnd ? PW'($urandom_range(0, 32767)) : PW'(r * 16 + c), (r == 0 && c == 0), bub);
   endtask

   task automatic drain();
      repeat (LW + 6) @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, act, req);
      end
   endtask

   task automatic check_win(input string name, input int idx, input int p0, input int p1, input int p2,
                            input bit sof, input bit eol);
      checks++;
      if (idx >= got.size()) begin
         errors++;
         $display("FAIL %s got no window %0d exp {%0d,%0d,%0d}", name, idx, p0, p1, p2);
      end else if (got[idx].p0 != p0 || got[idx].p1 != p1 || got[idx].p2 != p2 ||
                   got[idx].sof != sof || got[idx].eol != eol) begin
         errors++;
         $display("FAIL %s got {%0d,%0d,%0d} sof %0b eol %0b exp {%0d,%0d,%0d} sof %0b eol %0b", name,
                  got[idx].p0, got[idx].p1, got[idx].p2, got[idx].sof, got[idx].eol, p0, p1, p2, sof, eol);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (win_valid !== 1'b0 || win_sof !== 1'b0 || win_eol !== 1'b0 || win_pix_0 !== '0 ||
          win_pix_1 !== '0 || win_pix_2 !== '0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s got valid %0b sof %0b eol %0b pix {%0d,%0d,%0d} ready %0b exp all 0 ready 1",
                  name, win_valid, win_sof, win_eol, win_pix_0, win_pix_1, win_pix_2, s_ready);
      end
   endtask

   initial begin
      #1;
      check_reset_outputs("reset_state");
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;

      // Clean frame with literal spot checks.
      got.delete(); not_ready_cnt = 0;
      send_frame(0, 0);
      drain();
      $display("frame clean: windows %0d", got.size());
      check_int("clean_count", got.size(), 12);
      check_int("flush_ready_low", not_ready_cnt, 4);
      check_win("win_0_0", 0, 0, 0, 16, 1, 0);
      check_win("win_0_1", 1, 1, 1, 17, 0, 0);
      check_win("win_1_2", 6, 2, 18, 34, 0, 0);
      check_win("win_2_3", 11, 19, 35, 35, 0, 1);

      // Same pixels with 50% input bubbles.
      got.delete();
      send_frame(50, 0);
      drain();
      $display("frame bubbles: windows %0d", got.size());
      check_int("bubble_count", got.size(), 12);
      check_win("bub_1_2", 6, 2, 18, 34, 0, 0);

      // Random pixel values with bubbles.
      got.delete();
      send_frame(30, 1);
      drain();
      $display("frame random: windows %0d", got.size());
      check_int("random_count", got.size(), 12);

      // Abort at row 1 col 2 by a new sof.
      got.delete();
      for (int c = 0; c < LW; c++) send(PW'(c), (c == 0), 0);
      send(PW'(16), 1'b0, 0);
      send(PW'(17), 1'b0, 0);
      send_frame(0, 0);
      drain();
      $display("frame abort: windows %0d", got.size());
      check_int("abort_count", got.size(), 14);
      check_win("abort_old_0", 0, 0, 0, 16, 1, 0);
      check_win("abort_old_1", 1, 1, 1, 17, 0, 0);
      check_win("abort_new_0", 2, 0, 0, 16, 1, 0);

      // Reset pulsed during RUN.
      for (int c = 0; c < LW; c++) send(PW'(c), (c == 0), 0);
      for (int c = 0; c < 3; c++) send(PW'(16 + c), 1'b0, 0);
      arst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_run");
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
      got.delete();
      for (int i = 0; i < 5; i++) send(PW'($urandom_range(0, 32767)), 1'b0, 0);
      drain();
      $display("post reset no-sof pixels: windows %0d", got.size());
      check_int("post_reset_silent", got.size(), 0);
      send_frame(0, 0);
      drain();
      $display("frame after reset: windows %0d", got.size());
      check_int("post_reset_count", got.size(), 12);

      // Back-to-back frames, second sof presented during FLUSH.
      got.delete();
      send_frame(0, 0);
      send_frame(0, 0);
      drain();
      $display("frames back-to-back: windows %0d", got.size());
      check_int("b2b_count", got.size(), 24);
      check_win("b2b_second_first", 12, 0, 0, 16, 1, 0);

      check_int("pending_expected", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule

// File: doc/bpr_line_window.md
Name: bpr_line_window

Overview:
- Upstream feeder for the 3x1 column-interpolation stage of the bad-pixel replacer.
- Turns a raster pixel stream into vertical 3-pixel windows (row above, centre, row below) for every pixel of the frame.
- Uses two internal line buffers. Top and bottom frame edges are handled by replicating the edge row.
- win_valid drives the downstream cen. win_pix_0/1/2 feed pix_in_0/1/2.

Parameters:
- PIX_W, 15, pixel width in bits.
- LINE_W, 640, pixels per line; must be >= 2.
- FRAME_H, 512, lines per frame; must be >= 2.

Ports:
- clk  in  1  pixel clock.
- arst_n  in  1  asynchronous active-low reset.
- s_pix  in  PIX_W  input pixel.
- s_valid  in  1  input pixel valid.
- s_sof  in  1  start of frame; qualifies s_valid, marks row 0 col 0.
- s_ready  out  1  block accepts input; a transfer is s_valid & s_ready.
- win_pix_0  out  PIX_W  pixel at (row y-1, col x).
- win_pix_1  out  PIX_W  pixel at (row y, col x); the centre pixel.
- win_pix_2  out  PIX_W  pixel at (row y+1, col x).
- win_valid  out  1  window valid; one pulse per output pixel.
- win_sof  out  1  first window of a frame.
- win_eol  out  1  last column of a line (x = LINE_W-1).

Behaviour:
- Reset:
  - On arst_n low: state IDLE, counters 0, all win_* outputs 0.
  - s_ready = (state != FLUSH), so it reads 1 during reset.
  - Line RAM contents are not reset.
- Counters: col 0..LINE_W-1 and row 0..FRAME_H-1. col advances on every accepted pixel; at LINE_W-1 it wraps to 0 and row increments.
- Line buffers: lb_c holds the previous row; lb_t holds the row before that. Both use synchronous read, one cycle.
- FSM:
  - IDLE: non-sof pixels are accepted and dropped. An accepted s_sof pixel sets col=0, row=0 and goes to FILL.
  - FILL (row 0): write lb_c[col] <= s_pix. No output. At end of line go to RUN.
  - RUN (input rows 1..FRAME_H-1): for input row r, col x:
    - emit window for centre row r-1: top = lb_t[x], or lb_c[x] when r-1 = 0; centre = lb_c[x]; bottom = s_pix.
    - then lb_t[x] <= lb_c[x] and lb_c[x] <= s_pix.
    - After the last pixel of row FRAME_H-1, go to FLUSH.
  - FLUSH: s_ready = 0. An internal col counter runs LINE_W cycles and emits row FRAME_H-1 with top = lb_t[x], centre = lb_c[x], bottom = lb_c[x] (replicated). Then go to IDLE.
- Latency: win_* is registered and appears 2 clk after the accepting cycle, or 2 clk after the FLUSH read cycle. Output order is strict raster, with exactly LINE_W*FRAME_H windows per frame.
- win_sof is asserted on the window (row 0, col 0). win_eol is asserted on every col LINE_W-1 window. Both are 0 whenever win_valid = 0.
- Input bubbles (s_valid = 0): no state change, no output. Pipeline registers hold; win_valid = 0 in the matching output cycle.
- s_sof in FILL or RUN: the current frame is aborted, with no flush of the partial frame. That pixel becomes row 0 col 0 of a new FILL. Windows already in the 2-stage pipeline still drain.
- s_sof on a pixel other than the first while in IDLE cannot occur; the first sof wins.
- Reset mid-frame: immediate return to IDLE. In-flight windows are discarded and the next frame requires s_sof.
- Same-address RAM read/write in one cycle: read returns the old data (read-before-write). This is required for the lb_c -> lb_t shift.
- No arithmetic is performed; all pixel widths are PIX_W, passed through unmodified.

Decomposition:
- Shared package bpr_pkg:
  - PIX_W constant (15).
  - state typedef {IDLE, FILL, RUN, FLUSH}.
  - default LINE_W/FRAME_H constants shared with the other bpr stages.
- One sub-module, bpr_line_ram: simple dual-port LINE_W x PIX_W RAM with synchronous read-before-write. It is instantiated twice, for lb_c and lb_t.

Test Plan (LINE_W=4, FRAME_H=3; pixel value = row*16 + col):
- Reset, then one full frame streamed with no bubbles -> 12 windows in raster order.
  - (0,1) = {1,1,17} with win_sof=0.
  - (0,0) = {0,0,16} with win_sof=1.
  - (1,2) = {2,18,34}.
- Same frame -> FLUSH: s_ready=0 for exactly 4 cycles starting the cycle after pixel (2,3) is accepted.
  - last window (2,3) = {19,35,35} with win_eol=1.
  - s_ready returns to 1 afterwards.
- Random s_valid bubbles at 50% -> identical window sequence to the bubble-free run.
  - win_valid count = 12.
  - each win_valid lands exactly 2 clk after its accepting cycle.
- s_sof reasserted at row 1 col 2, followed by a full frame -> the aborted frame emits only its row-0 windows already issued. The new frame then produces the full 12 correct windows.
- arst_n pulsed low during RUN -> all win_* = 0 asynchronously and s_ready=1. Pixels before the next s_sof produce no windows.
- Two back-to-back frames, with the second s_sof presented during FLUSH -> the sof pixel is held until s_ready=1. The second frame's output starts with win_sof=1 and {0,0,16}.
